// File: rtl/can_tx_stuffer_if.sv
// Bit handshake between the TX frame sequencer (master) and the bit stuffer (slave).
// One bit moves per nominal bit time when in_valid and in_ready are both high.
interface can_tx_stuffer_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/can_tx_stuffer.sv
// Transmit-side CAN bit stuffer: inserts a complementary bit after RUN_LIMIT equal bits
// while stuffing is enabled, stalling the sequencer for that bit time.
module can_tx_stuffer #(
  parameter int RUN_LIMIT = 5,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_bit_tick,
  input  logic               i_frame_start,
  input  logic               i_en_stuff,
  can_tx_stuffer_if.slave    seq,
  output logic               o_tx_bit,
  output logic               o_stuff_bit,
  output logic               o_underrun,
  output logic [CNT_W-1:0]   o_stuff_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STUFF} state_t;

  localparam logic [2:0] LP_RUN_LIMIT = 3'(RUN_LIMIT);

  state_t             r_state,       w_nxt_state;
  logic               r_last_bit,    w_nxt_last;
  logic [2:0]         r_run_len,     w_nxt_run;
  logic               r_stuff_pend,  w_nxt_pend;
  logic               r_tx_bit,      w_nxt_tx;
  logic               r_stuff_bit,   w_nxt_stuff;
  logic               r_underrun,    w_nxt_und;
  logic [CNT_W-1:0]   r_stuff_count, w_nxt_cnt;

  logic               w_pend;
  logic               w_last_cmp;
  logic [2:0]         w_run_cmp;
  logic [2:0]         w_run_new;

  // frame_start takes effect before a coincident bit_tick, so it masks a stale pending stuff.
  assign w_pend       = r_stuff_pend & ~i_frame_start;
  assign seq.in_ready = i_bit_tick & ~w_pend;

  // A bit accepted on the SOF tick counts the recessive idle level as part of its run.
  assign w_last_cmp = i_frame_start ? 1'b1 : r_last_bit;
  assign w_run_cmp  = i_frame_start ? 3'd1 : r_run_len;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_nxt_state = i_frame_start ? ST_RUN : r_state;
    w_nxt_last  = i_frame_start ? 1'b1   : r_last_bit;
    w_nxt_run   = i_frame_start ? 3'd0   : r_run_len;
    w_nxt_cnt   = i_frame_start ? '0     : r_stuff_count;
    w_nxt_pend  = w_pend;
    w_nxt_tx    = r_tx_bit;
    w_nxt_stuff = r_stuff_bit;
    w_nxt_und   = 1'b0;
    w_run_new   = 3'd0;

    if (i_bit_tick) begin
      if (w_pend) begin
        // The pending stuff bit goes out even if en_stuff has already dropped.
        w_nxt_tx    = ~r_last_bit;
        w_nxt_stuff = 1'b1;
        w_nxt_last  = ~r_last_bit;
        w_nxt_run   = 3'd1;
        w_nxt_pend  = 1'b0;
        w_nxt_cnt   = (&r_stuff_count) ? r_stuff_count : r_stuff_count + CNT_W'(1);
        w_nxt_state = ST_RUN;
      end else if (seq.in_valid) begin
        w_nxt_tx    = seq.in_bit;
        w_nxt_stuff = 1'b0;
        w_nxt_last  = seq.in_bit;
        w_nxt_state = ST_RUN;
        if (i_en_stuff) begin
          w_run_new = (seq.in_bit == w_last_cmp) ? w_run_cmp + 3'd1 : 3'd1;
          w_nxt_run = w_run_new;
          if (w_run_new == LP_RUN_LIMIT) begin
            w_nxt_pend  = 1'b1;
            w_nxt_state = ST_STUFF;
          end
        end else begin
          w_nxt_run = 3'd0;
        end
      end else begin
        w_nxt_tx    = 1'b1;
        w_nxt_stuff = 1'b0;
        w_nxt_und   = 1'b1;
        w_nxt_run   = 3'd0;
        w_nxt_last  = 1'b1;
        w_nxt_state = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_bit    <= 1'b1;
      r_run_len     <= 3'd0;
      r_stuff_pend  <= 1'b0;
      r_tx_bit      <= 1'b1;
      r_stuff_bit   <= 1'b0;
      r_underrun    <= 1'b0;
      r_stuff_count <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_last_bit    <= w_nxt_last;
      r_run_len     <= w_nxt_run;
      r_stuff_pend  <= w_nxt_pend;
      r_tx_bit      <= w_nxt_tx;
      r_stuff_bit   <= w_nxt_stuff;
      r_underrun    <= w_nxt_und;
      r_stuff_count <= w_nxt_cnt;
    end
  end

  assign o_tx_bit      = r_tx_bit;
  assign o_stuff_bit   = r_stuff_bit;
  assign o_underrun    = r_underrun;
  assign o_stuff_count = r_stuff_count;

endmodule

// File: doc/can_tx_stuffer.md
Name: can_tx_stuffer

Overview:
- Transmit-side CAN bit stuffer: the counterpart of the receive-side destuffing logic in the decoder.
- Takes the unstuffed frame bitstream from the TX frame sequencer via a valid/ready handshake, one bit per nominal bit time.
- Drives the stuffed serial bit to the transceiver.
- After RUN_LIMIT consecutive identical bits while stuffing is enabled, it inserts one complementary stuff bit and stalls the sequencer for that bit time.

Parameters:
- RUN_LIMIT, 5, number of equal consecutive bits that triggers a stuff bit.
- CNT_W, 8, width of the stuff_count statistic counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- bit_tick  in  1  one-cycle strobe at the start of each nominal bit time, from bit timing.
- frame_start  in  1  one-cycle pulse marking SOF; clears run history and statistics.
- en_stuff  in  1  1 = stuffing region (SOF..CRC sequence); 0 = CRC delimiter, ACK, EOF, IFS.
- in_valid  in  1  sequencer has a bit to send.
- in_bit  in  1  bit value (0 = dominant).
- in_ready  out  1  combinational: bit_tick & ~stuff_pend; transfer occurs when in_valid & in_ready.
- tx_bit  out  1  registered serial output; reset 1 (recessive).
- stuff_bit  out  1  registered; high for the whole bit time in which tx_bit is a stuff bit; reset 0.
- underrun  out  1  one-cycle pulse: bit_tick with no stuff pending and in_valid=0; reset 0.
- stuff_count  out  CNT_W  stuff bits inserted since frame_start; saturates at all-ones; reset 0.

Behaviour:
- State: last_bit (reset 1), run_len (3 bits, reset 0), stuff_pend (reset 0), FSM {IDLE, RUN, STUFF}, reset IDLE.
- All outputs and state update only in cycles with bit_tick=1, except frame_start and reset.
- Latency: tx_bit takes the new value one clk after the bit_tick cycle and holds it until the next update.
- RUN, bit_tick, stuff_pend=0, in_valid=1:
  - tx_bit <= in_bit; stuff_bit <= 0.
  - If en_stuff=1: if in_bit==last_bit then run_len+1, else run_len <= 1. last_bit <= in_bit.
  - If the new run_len == RUN_LIMIT: stuff_pend <= 1, go to STUFF.
  - If en_stuff=0: run_len <= 0; no stuff is ever scheduled.
- STUFF, bit_tick:
  - tx_bit <= ~last_bit; stuff_bit <= 1; last_bit <= ~last_bit; run_len <= 1.
  - stuff_pend <= 0; stuff_count increments (saturating); go to RUN.
  - in_ready=0 this tick, so the sequencer's bit is held.
- A pending stuff bit is always emitted even if en_stuff falls before it. This covers the stuff bit after the last CRC bit.
- The stuff bit counts as bit 1 of a new run. It can therefore combine with following equal data bits to trigger another stuff.
- Underrun (bit_tick, no stuff pending, in_valid=0):
  - tx_bit <= 1; stuff_bit <= 0; underrun pulses.
  - run_len <= 0; last_bit <= 1; go to IDLE.
- IDLE behaves like RUN with run_len=0. Leave IDLE on the first accepted bit.
- frame_start:
  - Clears run_len, stuff_pend and stuff_count; last_bit <= 1; FSM to RUN.
  - With simultaneous bit_tick, frame_start applies first. The bit accepted on that tick starts a run of length 1, or 2 if it is 1.
- Run counting with en_stuff=0: no stuffing occurs. On re-enable the count restarts from the next bit (run_len = 1).
- Reset mid-frame: immediately tx_bit=1, stuff_bit=0, underrun=0, stuff_pend=0, run_len=0, stuff_count=0, FSM IDLE. in_ready is 0 until bit_tick.
- in_valid with bit_tick low is ignored; no transfer occurs.

Test Plan:
- frame_start, en_stuff=1, bits 0,0,0,0,0,1,1 -> tx_bit 0,0,0,0,0,1(stuff_bit=1),1,1. in_ready low on stuff tick. stuff_count=1.
- en_stuff=1, bits 0×5 then 1,1,1,1,0 -> tx 00000, stuff 1, then 1111, then second stuff 0 (stuff+4 ones = 5), then data 0. stuff_count=2.
- en_stuff=0, eight 1 bits -> tx 11111111, stuff_bit never high, stuff_count=0.
- en_stuff=1 for 5 zeros, en_stuff dropped on the next tick -> stuff 1 still emitted, then following bits unstuffed.
- in_valid=0 on a tick mid-run of three 0s -> tx_bit=1, underrun pulse. The next 0 bits restart the count, so 5 more zeros are needed before a stuff.
- Reset asserted during a STUFF pending bit time -> tx_bit=1 and stuff_pend=0 asynchronously. After release, the first tick with in_valid=0 gives tx_bit=1 and no stuff.
